// File: rtl/shift_seq_detect_if.sv
// Serial bit link between a bit source and the sequence detector.
interface shift_seq_detect_if;
    logic in;
    logic seq_out;

    // Bit source side: drives the serial bit, observes the match flag.
    modport master (
        output in,
        input  seq_out
    );

    // Detector side: consumes the serial bit, produces the match flag.
    modport slave (
        input  in,
        output seq_out
    );
endinterface

// File: rtl/shift_seq_detect.sv
// Serial sequence detector: shifts one bit per clock into a LEN-bit register
// and flags a match while the last LEN sampled bits equal PATTERN.
// PATTERN MSB is the oldest bit, LSB the newest. Overlapping matches are
// reported because the register is never cleared on a match.
module shift_seq_detect #(
    parameter int unsigned    LEN     = 5,
    parameter logic [LEN-1:0] PATTERN = 5'b10101
) (
    input  logic               clk,
    input  logic               reset,
    shift_seq_detect_if.slave  sd
);

    localparam int unsigned FW = $clog2(LEN + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(LEN);

    logic [LEN-1:0] r_sr;
    logic [FW-1:0]  r_fill;
    logic           w_full;
    logic           w_match;

    // Shift history in and count bits seen since reset, saturating at LEN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr   <= '0;
            r_fill <= '0;
        end else begin
            r_sr <= {r_sr[LEN-2:0], sd.in};
            if (r_fill != FILL_FULL) begin
                r_fill <= r_fill + FW'(1);
            end
        end
    end

    // Match only once the register holds LEN real samples, so the zeroed
    // reset contents can never alias a pattern containing zeros.
    always_comb begin
        w_full  = (r_fill == FILL_FULL);
        w_match = w_full && (r_sr == PATTERN);
    end

    assign sd.seq_out = w_match;

endmodule

// File: tb/tb_shift_seq_detect.sv
// Directed bench for shift_seq_detect: default 5-bit 10101 detector plus a
// 3-bit all-zero instance for the parameter sweep.
module tb_shift_seq_detect;

    logic clk;
    logic reset5;
    logic reset3;

    int unsigned n_assert;
    int unsigned n_fail;

    shift_seq_detect_if if5 ();
    shift_seq_detect_if if3 ();

    shift_seq_detect u_dut5 (
        .clk   (clk),
        .reset (reset5),
        .sd    (if5.slave)
    );

    shift_seq_detect #(
        .LEN     (3),
        .PATTERN (3'b000)
    ) u_dut3 (
        .clk   (clk),
        .reset (reset3),
        .sd    (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: seq_out=%b expected %b", tag, obs, exp);
        end
    endtask

    // One clock on the 5-bit instance, then check seq_out just after the edge.
    task automatic step5(input logic b, input logic rst, input logic exp, input string tag);
        if5.in = b;
        reset5 = rst;
        @(posedge clk);
        #1;
        check(tag, if5.seq_out, exp);
    endtask

    task automatic step3(input logic b, input logic rst, input logic exp, input string tag);
        if3.in = b;
        reset3 = rst;
        @(posedge clk);
        #1;
        check(tag, if3.seq_out, exp);
    endtask

    // Drive a bit string (first char first) with per-bit expected outputs.
    task automatic drive5(input string bits, input string exp, input string tag);
        for (int i = 0; i < bits.len(); i++) begin
            step5(bits[i] == "1", 1'b0, exp[i] == "1", $sformatf("%s[%0d]", tag, i + 1));
        end
    endtask

    task automatic reset5_pulse(input string tag);
        step5(1'b1, 1'b1, 1'b0, tag);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset5   = 1'b1;
        reset3   = 1'b1;
        if5.in   = 1'b0;
        if3.in   = 1'b0;

        // Reset held 10 cycles with input toggling.
        for (int i = 0; i < 10; i++) begin
            step5(i[0], 1'b1, 1'b0, $sformatf("rst_hold[%0d]", i));
        end

        // Main stream: pulses after bits 7, 12 and 22 only.
        drive5("0010101101011100010101100",
               "0000001000010000000001000", "main");

        // Overlap: 1010101 gives pulses after bits 5 and 7.
        reset5_pulse("ovl_rst");
        drive5("1010101", "0000101", "overlap");

        // Reset while a match is showing clears it immediately.
        reset5_pulse("ovl_clr");

        // Near misses.
        drive5("10100", "00000", "near_a");
        reset5_pulse("near_rst");
        drive5("10111", "00000", "near_b");

        // Mid-sequence reset discards partial history.
        reset5_pulse("mid_rst0");
        drive5("1010", "0000", "mid_pre");
        reset5_pulse("mid_rst1");
        drive5("1", "0", "mid_one");
        drive5("0101", "0001", "mid_post");

        // Reset on the edge that samples the final 1 of 10101.
        reset5_pulse("sim_rst0");
        drive5("1010", "0000", "sim_pre");
        step5(1'b1, 1'b1, 1'b0, "sim_edge");
        drive5("0000", "0000", "sim_post");

        // Parameter sweep: LEN=3, PATTERN=000.
        step3(1'b1, 1'b1, 1'b0, "p3_rst0");
        step3(1'b0, 1'b1, 1'b0, "p3_rst1");
        step3(1'b0, 1'b0, 1'b0, "p3_b1");
        step3(1'b0, 1'b0, 1'b0, "p3_b2");
        step3(1'b0, 1'b0, 1'b1, "p3_b3");
        step3(1'b0, 1'b0, 1'b1, "p3_b4");
        step3(1'b1, 1'b0, 1'b0, "p3_b5");
        step3(1'b0, 1'b0, 1'b0, "p3_b6");
        step3(1'b0, 1'b0, 1'b0, "p3_b7");
        step3(1'b0, 1'b0, 1'b1, "p3_b8");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
